irq_ctrl: RTL and testbench

- Interrupt controller that sequences accelerator completion events (done) into one CPU interrupt request.
- Latches events as pending, applies a programmable mask, and selects the lowest-index unmasked pending source (source 0 = highest priority).
- Presents a vector address to the CPU and runs an irq/ack/eoi handshake so only one source is in service at a time.
- Sits between the accelerator done lines and the CPU exception/interrupt input.

---
 rtl/irq_ctrl.sv | 140 ++++++++++++++
 tb/tb_irq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detects accelerator done lines, latches them as pending, and
// hands the lowest-index unmasked source to the CPU via an irq/ack/eoi handshake. Optional IRQ_OVF_EN.
module irq_ctrl #(
   parameter int          NUM_SRC    = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
   parameter logic [31:0] VEC_STRIDE = 32'd4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] done,
   input  logic               mask_wr,
   input  logic [NUM_SRC-1:0] mask_din,
   output logic [NUM_SRC-1:0] mask_q,
   output logic               irq,
   output logic [31:0]        EAddr,
   output logic [3:0]         irq_id,
   input  logic               irq_ack,
   input  logic               eoi,
   output logic [NUM_SRC-1:0] pending,
`ifdef IRQ_OVF_EN
   output logic [NUM_SRC-1:0] ovf,
   input  logic               ovf_clr,
`endif
   output logic               busy,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // Handshake: irq stays high with EAddr/irq_id stable until a one-cycle irq_ack while in REQ;
   // a one-cycle eoi while in SERVICE returns to IDLE. Strobes in any other state are ignored.

   state_t               r_state;
   state_t               w_state_n;
   logic [NUM_SRC-1:0]   r_done_d;
   logic [NUM_SRC-1:0]   r_pending;
   logic [NUM_SRC-1:0]   r_mask;
   logic                 r_irq;
   logic [31:0]          r_eaddr;
   logic [3:0]           r_irq_id;

   logic [NUM_SRC-1:0]   w_event;
   logic [NUM_SRC-1:0]   w_elig;
   logic [NUM_SRC-1:0]   w_clr;
   logic [NUM_SRC-1:0]   w_pending_n;
   logic                 w_any;
   logic [3:0]           w_sel;
   logic                 w_ack;
   logic                 w_load;

   assign w_event     = done & ~r_done_d;
   assign w_elig      = r_pending & r_mask;
   assign w_ack       = irq_ack && (r_state == REQ);
   assign w_load      = (r_state == IDLE) && w_any;
   // A fresh event on the bit being acknowledged must survive, so set is applied after clear.
   assign w_pending_n = (r_pending & ~w_clr) | w_event;

   always_comb begin
      w_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_clr[i] = w_ack && (r_irq_id == 4'(i));
      end
   end

   // Scanning downward leaves the lowest eligible index as the winner.
   always_comb begin
      w_any = 1'b0;
      w_sel = 4'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_any = 1'b1;
            w_sel = 4'(i);
         end
      end
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE:    if (w_any)   w_state_n = REQ;
         REQ:     if (irq_ack) w_state_n = SERVICE;
         SERVICE: if (eoi)     w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_n;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_done_d  <= '0;
         r_pending <= '0;
         r_mask    <= '1;
         r_irq     <= 1'b0;
         r_eaddr   <= 32'h0;
         r_irq_id  <= 4'd0;
      end else begin
         r_done_d  <= done;
         r_pending <= w_pending_n;
         if (mask_wr) r_mask <= mask_din;
         if (w_load) begin
            r_irq    <= 1'b1;
            r_irq_id <= w_sel;
            r_eaddr  <= VEC_BASE + {28'd0, w_sel} * VEC_STRIDE;
         end else if (w_ack) begin
            r_irq    <= 1'b0;
         end
      end
   end

`ifdef IRQ_OVF_EN
   logic [NUM_SRC-1:0] r_ovf;
   logic [NUM_SRC-1:0] w_ovf_set;

   assign w_ovf_set = w_event & r_pending & ~w_clr;

   always_ff @(posedge clk) begin
      if (!rst) r_ovf <= '0;
      else      r_ovf <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
   end

   assign ovf = r_ovf;
`endif

   assign mask_q    = r_mask;
   assign irq       = r_irq;
   assign EAddr     = r_eaddr;
   assign irq_id    = r_irq_id;
   assign pending   = r_pending;
   assign busy      = (r_state != IDLE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: priority, masking, no-retraction, held level, reset mid-service,
// and the overflow flags when IRQ_OVF_EN is defined.
module tb_irq_ctrl;

   localparam int N = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  done;
   logic          mask_wr;
   logic [N-1:0]  mask_din;
   logic [N-1:0]  mask_q;
   logic          irq;
   logic [31:0]   EAddr;
   logic [3:0]    irq_id;
   logic          irq_ack;
   logic          eoi;
   logic [N-1:0]  pending;
   logic          busy;
   logic [1:0]    dbg_state;
`ifdef IRQ_OVF_EN
   logic [N-1:0]  ovf;
   logic          ovf_clr;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   irq_ctrl #(.NUM_SRC(N), .VEC_BASE(32'h0), .VEC_STRIDE(32'd4)) dut (
      .clk       (clk),
      .rst       (rst),
      .done      (done),
      .mask_wr   (mask_wr),
      .mask_din  (mask_din),
      .mask_q    (mask_q),
      .irq       (irq),
      .EAddr     (EAddr),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .eoi       (eoi),
      .pending   (pending),
`ifdef IRQ_OVF_EN
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
`endif
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; samples and drives both happen 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic pulse_done(input logic [N-1:0] v);
      done = v;
      step();
      done = '0;
   endtask

   task automatic do_ack();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
   endtask

   task automatic do_eoi();
      eoi = 1'b1;
      step();
      eoi = 1'b0;
   endtask

   task automatic write_mask(input logic [N-1:0] v);
      mask_wr  = 1'b1;
      mask_din = v;
      step();
      mask_wr  = 1'b0;
   endtask

   // scoreboard: compare the raised vector against the next expected one
   task automatic check_vec(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_irq"}, {31'd0, irq}, 32'd1);
         check({tag, "_eaddr"}, EAddr, e);
         check({tag, "_id"}, {28'd0, irq_id}, e >> 2);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_irq"},     {31'd0, irq},     32'd0);
      check({tag, "_eaddr"},   EAddr,            32'd0);
      check({tag, "_id"},      {28'd0, irq_id},  32'd0);
      check({tag, "_pending"}, {28'd0, pending}, 32'd0);
      check({tag, "_mask"},    {28'd0, mask_q},  32'hF);
      check({tag, "_busy"},    {31'd0, busy},    32'd0);
      check({tag, "_state"},   {30'd0, dbg_state}, 32'd0);
   endtask

   int irq_rises;
   logic prev_irq;

   initial begin
      rst      = 1'b0;
      done     = '0;
      mask_wr  = 1'b0;
      mask_din = '0;
      irq_ack  = 1'b0;
      eoi      = 1'b0;
`ifdef IRQ_OVF_EN
      ovf_clr  = 1'b0;
`endif
      step();
      step();
      check_reset_state("reset");
      rst = 1'b1;
      step();

      // single event on source 2: pending after one edge, irq after two
      pulse_done(4'b0100);
      check("t1_pending", {28'd0, pending}, 32'h4);
      check("t1_irq_early", {31'd0, irq}, 32'd0);
      step();
      exp_q.push_back(32'h8);
      check_vec("t1");
      check("t1_busy", {31'd0, busy}, 32'd1);
      do_ack();
      check("t1_ack_irq", {31'd0, irq}, 32'd0);
      check("t1_ack_pending", {28'd0, pending}, 32'h0);
      check("t1_ack_eaddr_hold", EAddr, 32'h8);
      check("t1_service_busy", {31'd0, busy}, 32'd1);
      do_eoi();
      check("t1_eoi_busy", {31'd0, busy}, 32'd0);

      // simultaneous events on 1 and 3: source 1 first
      pulse_done(4'b1010);
      step();
      exp_q.push_back(32'h4);
      exp_q.push_back(32'hC);
      check_vec("t2a");
      do_ack();
      check("t2_pending", {28'd0, pending}, 32'h8);
      do_eoi();
      check("t2_idle_irq", {31'd0, irq}, 32'd0);
      check("t2_idle_busy", {31'd0, busy}, 32'd0);
      step();
      check_vec("t2b");
      do_ack();
      do_eoi();

      // masked source latches pending but is not selected
      write_mask(4'b1110);
      check("t3_mask", {28'd0, mask_q}, 32'hE);
      pulse_done(4'b0001);
      step();
      step();
      check("t3_pending", {28'd0, pending}, 32'h1);
      check("t3_irq_masked", {31'd0, irq}, 32'd0);
      write_mask(4'b1111);
      check("t3_irq_not_yet", {31'd0, irq}, 32'd0);
      step();
      exp_q.push_back(32'h0);
      check_vec("t3");
      do_ack();
      do_eoi();

      // no retraction: source 0 arrives while source 3 is requested
      pulse_done(4'b1000);
      step();
      exp_q.push_back(32'hC);
      check_vec("t4a");
      pulse_done(4'b0001);
      step();
      check("t4_hold_eaddr", EAddr, 32'hC);
      check("t4_hold_id", {28'd0, irq_id}, 32'd3);
      check("t4_pending", {28'd0, pending}, 32'h9);
      // ack and eoi together in REQ: only the ack takes effect
      irq_ack = 1'b1;
      eoi     = 1'b1;
      step();
      irq_ack = 1'b0;
      eoi     = 1'b0;
      check("t4_ackeoi_busy", {31'd0, busy}, 32'd1);
      check("t4_ackeoi_state", {30'd0, dbg_state}, 32'd2);
      check("t4_ackeoi_pending", {28'd0, pending}, 32'h1);
      // stray ack in SERVICE is ignored
      do_ack();
      check("t4_stray_ack_pending", {28'd0, pending}, 32'h1);
      do_eoi();
      step();
      exp_q.push_back(32'h0);
      check_vec("t4b");
      do_ack();
      do_eoi();

      // held level: exactly one interrupt over 20 cycles
      done      = 4'b0010;
      irq_rises = 0;
      prev_irq  = irq;
      for (int i = 0; i < 20; i++) begin
         step();
         if (irq && !prev_irq) irq_rises++;
         prev_irq = irq;
         if (irq) begin
            irq_ack = 1'b1;
            step();
            irq_ack = 1'b0;
            eoi = 1'b1;
            step();
            eoi = 1'b0;
            prev_irq = irq;
         end
      end
      check("t5_one_irq", 32'(irq_rises), 32'd1);
      check("t5_pending", {28'd0, pending}, 32'h0);
      done = '0;
      step();

      // reset while in service
      write_mask(4'b0111);
      pulse_done(4'b0100);
      step();
      do_ack();
      pulse_done(4'b0001);
      check("t6_in_service", {31'd0, busy}, 32'd1);
      check("t6_pending_pre", {28'd0, pending}, 32'h1);
      rst = 1'b0;
      step();
      check_reset_state("t6_rst");
      rst = 1'b1;
      step();
      step();
      check("t6_no_irq_after", {31'd0, irq}, 32'd0);

`ifdef IRQ_OVF_EN
      // second event before ack sets the sticky overflow flag
      pulse_done(4'b0100);
      step();
      check("t7_irq", {31'd0, irq}, 32'd1);
      check("t7_ovf_none", {28'd0, ovf}, 32'h0);
      pulse_done(4'b0100);
      check("t7_ovf_set", {28'd0, ovf}, 32'h4);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("t7_ovf_clr", {28'd0, ovf}, 32'h0);
      do_ack();
      do_eoi();
`endif

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
